// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared dmem port: registered round-robin ownership
// with bounded bursts, combinational request mux, one-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             rd_pend0, rd_pend1;

  logic       own_req, oth_req;
  logic [1:0] oth_state;

  assign gnt0 = (state == OWN0) & req0;
  assign gnt1 = (state == OWN1) & req1;

  assign own_req   = (state == OWN1) ? req1 : req0;
  assign oth_req   = (state == OWN1) ? req0 : req1;
  assign oth_state = (state == OWN1) ? OWN0 : OWN1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt      = state;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        burst_cnt_nxt = '0;
        if (req0 && req1) state_nxt = last_owner ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_nxt     = oth_req ? oth_state : IDLE;
          burst_cnt_nxt = '0;
        end else begin
          last_owner_nxt = (state == OWN1);
          // Saturated counter: hand over only if the other side is waiting.
          if (burst_cnt == CNT_LAST) begin
            if (oth_req) begin
              state_nxt     = oth_state;
              burst_cnt_nxt = '0;
            end
          end else begin
            burst_cnt_nxt = burst_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        burst_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      burst_cnt  <= '0;
      rd_pend0   <= 1'b0;
      rd_pend1   <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
      rd_pend0   <= gnt0 & ~we0;
      rd_pend1   <= gnt1 & ~we1;
    end
  end

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (gnt0) begin
      address_dmem = addr0;
      data         = wdata0;
      wren         = we0;
    end else if (gnt1) begin
      address_dmem = addr1;
      data         = wdata1;
      wren         = we1;
    end
  end

  assign rvalid0 = rd_pend0;
  assign rvalid1 = rd_pend1;
  assign rdata0  = rd_pend0 ? q_dmem : '0;
  assign rdata1  = rd_pend1 ? q_dmem : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a tenure-based reference model predicts
// every beat and read return; a negedge monitor compares against the DUT.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  typedef struct {bit req; bit we; logic [11:0] addr; logic [31:0] wdata;} req_t;
  typedef struct {int g; bit we; logic [11:0] addr; logic [31:0] wdata;} beat_t;
  typedef struct {logic [31:0] data; int due;} rd_t;
  typedef struct {int g; bit rv0; bit rv1; bit wr; logic [11:0] a; logic [31:0] rd0;} obs_t;

  logic        clock, reset;
  logic        req0, we0, gnt0, rvalid0, req1, we1, gnt1, rvalid1, wren;
  logic [11:0] addr0, addr1, address_dmem;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, data, q_dmem;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .address_dmem(address_dmem), .data(data), .wren(wren), .q_dmem(q_dmem)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous dmem with one-cycle read latency.
  logic [31:0] dmem    [0:4095];
  logic [31:0] ref_mem [0:4095];
  always @(posedge clock) begin
    if (wren) dmem[address_dmem] <= data;
    q_dmem <= dmem[address_dmem];
  end

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    mon_en   = 1'b0;
  beat_t gq [$];
  rd_t   rq0 [$];
  rd_t   rq1 [$];
  obs_t  log_q [$];

  // Reference model: current owner (-1 = none), beats taken in this tenure, last beat port.
  int own  = -1;
  int run  = 0;
  int last = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst, input req_t p0, input req_t p1, output int g);
    req_t  p [2];
    beat_t b;
    rd_t   r;
    int    o;
    p[0] = p0;
    p[1] = p1;
    cyc++;
    reset = rst;
    req0 = p0.req; we0 = p0.we; addr0 = p0.addr; wdata0 = p0.wdata;
    req1 = p1.req; we1 = p1.we; addr1 = p1.addr; wdata1 = p1.wdata;
    g = -1;
    if (own >= 0) begin
      if (p[own].req) g = own;
    end
    b = '{g: g, we: 1'b0, addr: 12'h0, wdata: 32'h0};
    if (g >= 0) begin
      b.we = p[g].we; b.addr = p[g].addr; b.wdata = p[g].wdata;
      if (p[g].we) ref_mem[p[g].addr] = p[g].wdata;
      else if (!rst) begin
        r = '{data: ref_mem[p[g].addr], due: cyc + 1};
        if (g == 0) rq0.push_back(r); else rq1.push_back(r);
      end
    end
    gq.push_back(b);
    if (rst) begin
      own = -1; run = 0; last = 1;
    end else if (own < 0) begin
      run = 0;
      if (p[0].req && p[1].req) own = 1 - last;
      else if (p[0].req)        own = 0;
      else if (p[1].req)        own = 1;
    end else begin
      o = own;
      if (!p[o].req) begin
        own = p[1-o].req ? 1 - o : -1;
        run = 0;
      end else begin
        last = o;
        run++;
        if (run >= MAXB && p[1-o].req) begin
          own = 1 - o;
          run = 0;
        end
      end
    end
    mon_en = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_rd(input int p, input logic rv, input logic [31:0] rd);
    rd_t h;
    bit  have;
    have = 1'b0;
    h = '{data: 32'h0, due: 0};
    if (p == 0 && rq0.size() > 0 && rq0[0].due == cyc) begin h = rq0.pop_front(); have = 1'b1; end
    if (p == 1 && rq1.size() > 0 && rq1[0].due == cyc) begin h = rq1.pop_front(); have = 1'b1; end
    check($sformatf("rvalid%0d", p), {63'b0, rv}, {63'b0, have});
    check($sformatf("rdata%0d", p), {32'b0, rd}, {32'b0, h.data});
  endtask

  always @(negedge clock) begin
    beat_t e;
    obs_t  ob;
    if (mon_en) begin
      if (gq.size() == 0) begin
        check("beat_queue_underflow", 64'd1, 64'd0);
      end else begin
        e = gq.pop_front();
        check("gnt0", {63'b0, gnt0}, {63'b0, e.g == 0});
        check("gnt1", {63'b0, gnt1}, {63'b0, e.g == 1});
        check("wren", {63'b0, wren}, {63'b0, e.we});
        check("address_dmem", {52'b0, address_dmem}, {52'b0, e.addr});
        check("data", {32'b0, data}, {32'b0, e.wdata});
      end
      check("rvalid_exclusive", {63'b0, rvalid0 & rvalid1}, 64'd0);
      chk_rd(0, rvalid0, rdata0);
      chk_rd(1, rvalid1, rdata1);
      ob.g   = gnt0 ? 0 : (gnt1 ? 1 : -1);
      ob.rv0 = rvalid0;
      ob.rv1 = rvalid1;
      ob.wr  = wren;
      ob.a   = address_dmem;
      ob.rd0 = rdata0;
      log_q.push_back(ob);
    end
  end

  function automatic req_t rand_req();
    req_t r;
    r.req   = ($urandom_range(3) != 0);
    r.we    = 1'($urandom_range(1));
    r.addr  = 12'h100 | 12'($urandom_range(15));
    r.wdata = $urandom;
    return r;
  endfunction

  function automatic req_t next_req(input req_t c, input bit granted);
    req_t r;
    r = c;
    if (granted) r = rand_req();
    else if (c.req) begin
      if ($urandom_range(15) == 0) r.req = 1'b0;
    end else if ($urandom_range(1) == 1) r = rand_req();
    return r;
  endfunction

  initial begin
    req_t nop, a0, a1, c0, c1;
    int   g, nb, cnt, nwr;
    int   pat2 [10];
    int   pat4 [9];
    logic [11:0] a5, wa;
    logic [31:0] rdv;
    bit   rst, any1;

    nop = '{req: 1'b0, we: 1'b0, addr: 12'h0, wdata: 32'h0};
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 4096; i++) begin
      dmem[i]    = {4'hA, 12'(i), 4'h5, 12'(i)};
      ref_mem[i] = {4'hA, 12'(i), 4'h5, 12'(i)};
    end
    dmem[12'h010]    = 32'hDEADBEEF;
    ref_mem[12'h010] = 32'hDEADBEEF;
    @(posedge clock);
    #1;
    check("rst_gnt0", {63'b0, gnt0}, 64'd0);
    check("rst_gnt1", {63'b0, gnt1}, 64'd0);
    check("rst_rvalid0", {63'b0, rvalid0}, 64'd0);
    check("rst_rvalid1", {63'b0, rvalid1}, 64'd0);
    check("rst_rdata0", {32'b0, rdata0}, 64'd0);
    check("rst_rdata1", {32'b0, rdata1}, 64'd0);
    check("rst_wren", {63'b0, wren}, 64'd0);
    check("rst_address", {52'b0, address_dmem}, 64'd0);
    check("rst_data", {32'b0, data}, 64'd0);

    // Single read from port 0 straight after reset.
    log_q.delete();
    a0 = '{req: 1'b1, we: 1'b0, addr: 12'h010, wdata: 32'h0};
    step(0, a0, nop, g);
    step(0, a0, nop, g);
    step(0, nop, nop, g);
    step(0, nop, nop, g);
    check("t1_cycle1_idle", 64'(log_q[0].g), 64'(-1));
    check("t1_cycle2_gnt0", 64'(log_q[1].g), 64'd0);
    check("t1_rvalid0", {63'b0, log_q[2].rv0}, 64'd1);
    check("t1_rdata0", {32'b0, log_q[2].rd0}, {32'b0, 32'hDEADBEEF});
    any1 = 1'b0;
    foreach (log_q[i]) if (log_q[i].g == 1) any1 = 1'b1;
    check("t1_no_gnt1", {63'b0, any1}, 64'd0);

    // Simultaneous continuous requests after reset.
    step(1, nop, nop, g);
    log_q.delete();
    a0 = '{req: 1'b1, we: 1'b0, addr: 12'h030, wdata: 32'h0};
    a1 = '{req: 1'b1, we: 1'b0, addr: 12'h031, wdata: 32'h0};
    pat2 = '{-1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int k = 0; k < 10; k++) step(0, a0, a1, g);
    for (int k = 0; k < 10; k++) check($sformatf("t2_grant_%0d", k), 64'(log_q[k].g), 64'(pat2[k]));

    // Port 1 writes, port 0 reads it back.
    step(0, nop, nop, g);
    step(0, nop, nop, g);
    log_q.delete();
    a1 = '{req: 1'b1, we: 1'b1, addr: 12'h020, wdata: 32'h12345678};
    g = -1;
    for (int k = 0; k < 20 && g != 1; k++) step(0, nop, a1, g);
    check("t3_write_granted", 64'(g), 64'd1);
    a0 = '{req: 1'b1, we: 1'b0, addr: 12'h020, wdata: 32'h0};
    g = -1;
    for (int k = 0; k < 20 && g != 0; k++) step(0, a0, nop, g);
    check("t3_read_granted", 64'(g), 64'd0);
    step(0, nop, nop, g);
    step(0, nop, nop, g);
    nwr = 0; wa = '0; rdv = '0;
    foreach (log_q[i]) begin
      if (log_q[i].wr)  begin nwr++; wa = log_q[i].a; end
      if (log_q[i].rv0) rdv = log_q[i].rd0;
    end
    check("t3_wren_cycles", 64'(nwr), 64'd1);
    check("t3_wren_addr", {52'b0, wa}, 64'h020);
    check("t3_rdata0", {32'b0, rdv}, 64'h12345678);

    // Port 0 drops after two beats; port 1 then gets a full burst.
    step(1, nop, nop, g);
    log_q.delete();
    a0 = '{req: 1'b1, we: 1'b0, addr: 12'h040, wdata: 32'h0};
    a1 = '{req: 1'b1, we: 1'b0, addr: 12'h041, wdata: 32'h0};
    pat4 = '{-1, 0, 0, -1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 3; k++) step(0, a0, a1, g);
    step(0, nop, a1, g);
    for (int k = 0; k < 5; k++) step(0, a0, a1, g);
    for (int k = 0; k < 9; k++) check($sformatf("t4_grant_%0d", k), 64'(log_q[k].g), 64'(pat4[k]));

    // Port 0 uncontended for ten reads, then port 1 joins.
    step(1, nop, nop, g);
    log_q.delete();
    a5 = 12'h080;
    for (int k = 0; k < 11; k++) begin
      a0 = '{req: 1'b1, we: 1'b0, addr: a5, wdata: 32'h0};
      step(0, a0, nop, g);
      if (g == 0) a5++;
    end
    a1 = '{req: 1'b1, we: 1'b0, addr: 12'h090, wdata: 32'h0};
    nb = 0;
    g = -1;
    for (int k = 0; k < 10 && g != 1; k++) begin
      a0 = '{req: 1'b1, we: 1'b0, addr: a5, wdata: 32'h0};
      step(0, a0, a1, g);
      if (g == 0) begin nb++; a5++; end
    end
    check("t5_switched", 64'(g), 64'd1);
    check("t5_switch_within_burst", {63'b0, nb <= MAXB}, 64'd1);
    cnt = 0;
    for (int k = 1; k <= 10; k++) if (log_q[k].g == 0) cnt++;
    check("t5_gnt0_cycles", 64'(cnt), 64'd10);
    cnt = 0;
    for (int k = 2; k <= 11; k++) if (log_q[k].rv0) cnt++;
    check("t5_rvalid0_pulses", 64'(cnt), 64'd10);
    step(0, nop, nop, g);
    step(0, nop, nop, g);

    // Reset in the middle of a port 1 read burst.
    step(1, nop, nop, g);
    log_q.delete();
    a1 = '{req: 1'b1, we: 1'b0, addr: 12'h050, wdata: 32'h0};
    step(0, nop, a1, g);
    step(0, nop, a1, g);
    step(1, nop, a1, g);
    step(0, nop, a1, g);
    step(0, nop, nop, g);
    check("t6_beat_in_reset_cycle", 64'(log_q[2].g), 64'd1);
    check("t6_after_reset_no_gnt", 64'(log_q[3].g), 64'(-1));
    check("t6_after_reset_rvalid1", {63'b0, log_q[3].rv1}, 64'd0);
    check("t6_after_reset_wren", {63'b0, log_q[3].wr}, 64'd0);

    // Randomised traffic with occasional resets.
    c0 = nop;
    c1 = nop;
    for (int n = 0; n < 2000; n++) begin
      rst = ($urandom_range(199) == 0);
      step(rst, c0, c1, g);
      c0 = next_req(c0, g == 0);
      c1 = next_req(c1, g == 1);
    end
    for (int k = 0; k < 3; k++) step(0, nop, nop, g);
    mon_en = 1'b0;
    check("beat_queue_drained", 64'(gq.size()), 64'd0);
    check("rd0_queue_drained", 64'(rq0.size()), 64'd0);
    check("rd1_queue_drained", 64'(rq1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
